debug_frame_tx: RTL and testbench

Parametrised UART frame transmitter for the board-level debug path. It captures a snapshot of `NUM_WORDS` datapath words of `WORD_WIDTH` bits when `start` is asserted. It serialises that snapshot as one framed 8N1 byte stream: header, payload, then an XOR checksum. It runs in the 12.5 MHz DCM clock domain, alongside the datapath, and drives `uartTxPin` and the status LEDs/counter that the top level already exposes.

---
 rtl/debug_frame_pkg.sv | 18 +
 rtl/debug_frame_tx_if.sv | 24 ++
 rtl/uart_tx_byte.sv | 84 ++++++++
 rtl/debug_frame_tx.sv | 122 ++++++++++++
 tb/tb_debug_frame_tx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/debug_frame_pkg.sv
// Shared types and constants for the debug UART frame transmitter.
package debug_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CHECKSUM
    } frameState_t;

    typedef enum logic [1:0] {
        START,
        DATA,
        STOP
    } bitState_t;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/debug_frame_tx_if.sv
// Request/snapshot and status bundle between the datapath top level and the frame transmitter.
interface debug_frame_tx_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                            start;
    logic [NUM_WORDS*WORD_WIDTH-1:0] frame_data;
    logic                            uartTxPin;
    logic                            busy;
    logic                            ledIdle;
    logic                            sentFlag;
    logic [CNT_WIDTH-1:0]            sendCounter;

    modport master (
        output start, frame_data,
        input  uartTxPin, busy, ledIdle, sentFlag, sendCounter
    );

    modport slave (
        input  start, frame_data,
        output uartTxPin, busy, ledIdle, sentFlag, sendCounter
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; done is high during the last stop-bit cycle so the next
// byte can be loaded on the edge that ends it, giving back-to-back bytes.
module uart_tx_byte
    import debug_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 109
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       ready
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_WARN = BAUD_W'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2) begin : gBadBaud
        $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
    end

    bitState_t         bitState;
    logic [BAUD_W-1:0] baudCnt;
    logic [2:0]        bitIdx;
    logic [7:0]        shiftReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx       <= 1'b1;
            done     <= 1'b0;
            ready    <= 1'b1;
            bitState <= START;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                tx       <= 1'b0;
                shiftReg <= data;
                bitState <= START;
                baudCnt  <= '0;
                bitIdx   <= '0;
                ready    <= 1'b0;
            end else if (!ready) begin
                baudCnt <= (baudCnt == BAUD_LAST) ? '0 : baudCnt + 1'b1;
                case (bitState)
                    START: begin
                        if (baudCnt == BAUD_LAST) begin
                            bitState <= DATA;
                            tx       <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                        end
                    end
                    DATA: begin
                        if (baudCnt == BAUD_LAST) begin
                            if (bitIdx == 3'd7) begin
                                bitState <= STOP;
                                tx       <= 1'b1;
                            end else begin
                                bitIdx   <= bitIdx + 1'b1;
                                tx       <= shiftReg[0];
                                shiftReg <= shiftReg >> 1;
                            end
                        end
                    end
                    STOP: begin
                        // Raise done one cycle early so it coincides with the final stop-bit cycle.
                        if (baudCnt == BAUD_WARN) begin
                            done <= 1'b1;
                        end
                        if (baudCnt == BAUD_LAST) begin
                            ready <= 1'b1;
                        end
                    end
                    default: bitState <= START;
                endcase
            end
        end
    end

endmodule

// File: rtl/debug_frame_tx.sv
// Debug frame transmitter: snapshots frame_data on start and sends
// header, payload (LSB first per word) and XOR checksum as one 8N1 stream.
module debug_frame_tx
    import debug_frame_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned NUM_WORDS    = 4,
    parameter int unsigned CLKS_PER_BIT = 109,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    debug_frame_tx_if.slave  bus
);
    localparam int unsigned FRAME_BITS    = NUM_WORDS * WORD_WIDTH;
    localparam int unsigned PAYLOAD_BYTES = FRAME_BITS / 8;
    localparam int unsigned FRAME_BYTES   = PAYLOAD_BYTES + 2;
    localparam logic [CNT_WIDTH-1:0] LAST_PAYLOAD_CNT = CNT_WIDTH'(PAYLOAD_BYTES);

    if (WORD_WIDTH % 8 != 0) begin : gBadWordWidth
        $error("debug_frame_tx: WORD_WIDTH must be a multiple of 8");
    end
    if (FRAME_BYTES > (1 << CNT_WIDTH) - 1) begin : gBadCntWidth
        $error("debug_frame_tx: CNT_WIDTH too small for frame length");
    end

    frameState_t            state;
    logic [FRAME_BITS-1:0]  shadow;
    logic [7:0]             checksum;
    logic [CNT_WIDTH-1:0]   byteCount;
    logic                   busyReg;
    logic                   sentReg;
    logic [7:0]             payloadByte;
    logic [7:0]             uartData;
    logic                   uartLoad;
    logic                   uartDone;
    logic                   uartReady;
    logic                   txLine;

    // Byte select: byteCount bytes are complete, so the next payload byte is payload[byteCount].
    always_comb begin
        uartLoad    = 1'b0;
        uartData    = HEADER_BYTE;
        payloadByte = 8'(shadow >> {byteCount, 3'b000});
        case (state)
            IDLE: begin
                if (bus.start && uartReady) begin
                    uartLoad = 1'b1;
                end
            end
            SEND: begin
                if (uartDone) begin
                    uartLoad = 1'b1;
                    uartData = (byteCount == LAST_PAYLOAD_CNT) ? checksum : payloadByte;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            checksum  <= '0;
            byteCount <= '0;
            busyReg   <= 1'b0;
            sentReg   <= 1'b0;
        end else begin
            sentReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && uartReady) begin
                        state     <= SEND;
                        busyReg   <= 1'b1;
                        shadow    <= bus.frame_data;
                        byteCount <= '0;
                        checksum  <= '0;
                    end
                end
                SEND: begin
                    if (uartDone) begin
                        byteCount <= byteCount + 1'b1;
                        if (byteCount == LAST_PAYLOAD_CNT) begin
                            state <= CHECKSUM;
                        end else begin
                            checksum <= checksum ^ payloadByte;
                        end
                    end
                end
                CHECKSUM: begin
                    if (uartDone) begin
                        byteCount <= byteCount + 1'b1;
                        state     <= IDLE;
                        busyReg   <= 1'b0;
                        sentReg   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uTxByte (
        .clk   (clk),
        .reset (reset),
        .load  (uartLoad),
        .data  (uartData),
        .tx    (txLine),
        .done  (uartDone),
        .ready (uartReady)
    );

    assign bus.uartTxPin   = txLine;
    assign bus.busy        = busyReg;
    assign bus.ledIdle     = ~busyReg;
    assign bus.sentFlag    = sentReg;
    assign bus.sendCounter = byteCount;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Self-checking bench for debug_frame_tx: table vectors, random frames and
// hand sequences for the mid-frame start, async reset and back-to-back cases.
module tb_debug_frame_tx;
    localparam int unsigned WW        = 16;
    localparam int unsigned NW        = 2;
    localparam int unsigned CPB       = 4;
    localparam int unsigned CW        = 8;
    localparam int unsigned NB        = 6;
    localparam int unsigned BYTE_CYC  = 10 * CPB;
    localparam int unsigned FRAME_CYC = NB * BYTE_CYC;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    debug_frame_tx_if #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .CNT_WIDTH(CW)) bus ();

    debug_frame_tx #(
        .WORD_WIDTH(WW), .NUM_WORDS(NW), .CLKS_PER_BIT(CPB), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [47:0] bytes;   // byte i of the frame at [8*i +: 8]
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame content straight from the byte-order rules: header, words LSB first, XOR of payload.
    function automatic logic [47:0] modelBytes(input logic [31:0] d);
        logic [47:0] r;
        logic [7:0]  b;
        logic [7:0]  chk;
        int          idx;
        r        = '0;
        r[7:0]   = 8'hA5;
        chk      = 8'h00;
        idx      = 1;
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < WW / 8; k++) begin
                b = d[w*WW + k*8 +: 8];
                r[idx*8 +: 8] = b;
                chk = chk ^ b;
                idx++;
            end
        end
        r[idx*8 +: 8] = chk;
        return r;
    endfunction

    // Expected line level c cycles after the accepting edge.
    function automatic logic expLine(input logic [47:0] frameBytes, input int c);
        int         j;
        int         bitPos;
        logic [7:0] b;
        j      = c / BYTE_CYC;
        bitPos = (c % BYTE_CYC) / CPB;
        b      = frameBytes[j*8 +: 8];
        if (bitPos == 0) return 1'b0;
        if (bitPos == 9) return 1'b1;
        return b[bitPos-1];
    endfunction

    task automatic runFrame(input logic [31:0] d, input logic [47:0] exp, input int pokeCycle,
                            input logic hold, input string tag);
        logic       line[FRAME_CYC];
        logic [9:0] hdrWave;
        logic [7:0] got;
        int         waveBad, cntBad, busyBad, pulseBad, hdrBad, frameBad;
        waveBad = 0; cntBad = 0; busyBad = 0; pulseBad = 0; hdrBad = 0; frameBad = 0;
        hdrWave = 10'b11_0100_1010;   // start, A5 LSB first, stop (bit 0 first)

        bus.frame_data = d;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s accept busy", tag), bus.busy, 1'b1);
        check($sformatf("%s accept startbit", tag), bus.uartTxPin, 1'b0);

        for (int c = 0; c < int'(FRAME_CYC); c++) begin
            line[c] = bus.uartTxPin;
            if (bus.uartTxPin !== expLine(exp, c)) waveBad++;
            if (bus.sendCounter !== CW'(c / BYTE_CYC)) cntBad++;
            if (bus.busy !== 1'b1 || bus.ledIdle !== 1'b0) busyBad++;
            if (bus.sentFlag !== 1'b0) pulseBad++;
            bus.start = hold || (c == pokeCycle);
            if (c == pokeCycle) bus.frame_data = 32'hFFFF_FFFF;
            @(posedge clk); #1;
        end

        check($sformatf("%s wave mismatches", tag), waveBad, 0);
        check($sformatf("%s counter mismatches", tag), cntBad, 0);
        check($sformatf("%s busy mismatches", tag), busyBad, 0);
        check($sformatf("%s early sentFlag", tag), pulseBad, 0);
        check($sformatf("%s sentFlag", tag), bus.sentFlag, 1'b1);
        check($sformatf("%s busy end", tag), bus.busy, 1'b0);
        check($sformatf("%s ledIdle end", tag), bus.ledIdle, 1'b1);
        check($sformatf("%s sendCounter end", tag), bus.sendCounter, CW'(NB));
        check($sformatf("%s line idle", tag), bus.uartTxPin, 1'b1);

        for (int k = 0; k < 10; k++)
            for (int m = 0; m < int'(CPB); m++)
                if (line[k*CPB + m] !== hdrWave[k]) hdrBad++;
        check($sformatf("%s header waveform", tag), hdrBad, 0);

        // Decode each byte by sampling mid-bit.
        for (int j = 0; j < int'(NB); j++) begin
            if (line[j*BYTE_CYC + CPB/2] !== 1'b0 || line[j*BYTE_CYC + 9*CPB + CPB/2] !== 1'b1)
                frameBad++;
            for (int k = 0; k < 8; k++)
                got[k] = line[j*BYTE_CYC + (k+1)*CPB + CPB/2];
            check($sformatf("%s byte%0d", tag, j), got, exp[j*8 +: 8]);
        end
        check($sformatf("%s framing bits", tag), frameBad, 0);
    endtask

    task automatic expectQuiet(input int cycles, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.sentFlag !== 1'b0 || bus.uartTxPin !== 1'b1 ||
                bus.ledIdle !== 1'b1 || bus.sendCounter !== CW'(NB))
                bad++;
        end
        check($sformatf("%s quiet cycles", tag), bad, 0);
    endtask

    initial begin
        logic [31:0] d1;
        logic [31:0] d2;
        int          bad;

        vecs[0] = '{32'h5678_1234, 48'h08_56_78_12_34_A5};
        vecs[1] = '{32'h0000_0000, 48'h00_00_00_00_00_A5};
        vecs[2] = '{32'hFFFF_FFFF, 48'h00_FF_FF_FF_FF_A5};
        vecs[3] = '{32'h0102_0304, 48'h04_01_02_03_04_A5};
        vecs[4] = '{32'h0000_00A5, 48'hA5_00_00_00_A5_A5};

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.frame_data = '0;
        #2;
        check("reset uartTxPin", bus.uartTxPin, 1'b1);
        check("reset busy", bus.busy, 1'b0);
        check("reset ledIdle", bus.ledIdle, 1'b1);
        check("reset sentFlag", bus.sentFlag, 1'b0);
        check("reset sendCounter", bus.sendCounter, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.uartTxPin !== 1'b1 || bus.busy !== 1'b0 || bus.ledIdle !== 1'b1 ||
                bus.sentFlag !== 1'b0 || bus.sendCounter !== '0)
                bad++;
        end
        check("idle after reset", bad, 0);

        for (int i = 0; i < 5; i++)
            runFrame(vecs[i].data, vecs[i].bytes, -1, 1'b0, $sformatf("vec%0d", i));

        // Start pulse and data change during byte 2 must not disturb the frame.
        runFrame(32'h5678_1234, vecs[0].bytes, 2*BYTE_CYC + 5, 1'b0, "poke");
        expectQuiet(20, "poke");

        // Async reset during byte 3.
        bus.frame_data = 32'hCAFE_BEEF;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3*BYTE_CYC + 10) @(posedge clk);
        #1;
        check("pre-reset counter", bus.sendCounter, 3);
        #2 reset = 1'b1;
        #1;
        check("abort line", bus.uartTxPin, 1'b1);
        check("abort counter", bus.sendCounter, 0);
        check("abort busy", bus.busy, 1'b0);
        check("abort sentFlag", bus.sentFlag, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.sentFlag !== 1'b0 || bus.busy !== 1'b0 || bus.uartTxPin !== 1'b1) bad++;
        end
        check("post-abort quiet", bad, 0);
        runFrame(32'h1357_9BDF, modelBytes(32'h1357_9BDF), -1, 1'b0, "afterAbort");

        // Start held across sentFlag: second frame starts the cycle after the pulse.
        d1 = $urandom;
        d2 = $urandom;
        runFrame(d1, modelBytes(d1), -1, 1'b1, "b2b1");
        runFrame(d2, modelBytes(d2), -1, 1'b0, "b2b2");
        expectQuiet(10, "b2b");

        for (int i = 0; i < 4; i++) begin
            d1 = $urandom;
            runFrame(d1, modelBytes(d1), -1, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
